// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared constants and pointer type for the dual-port RAM FIFO
package dpram_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  // Pointer carries one extra wrap bit above the RAM address.
  typedef logic [ADDR_W:0] ptr_t;

endpackage

// File: rtl/fifo_out_buf.sv
// rtl/fifo_out_buf.sv - 2-entry output skid buffer absorbing the RAM read latency
module fifo_out_buf #(
  parameter int DATA_W = dpram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              land,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              pop,
  output logic [1:0]        buf_cnt,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_idx;
  logic              rd_idx;

  // Capture landing RAM words and retire popped ones; flush drops anything in the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_idx  <= 1'b0;
      rd_idx  <= 1'b0;
      buf_cnt <= 2'd0;
    end else if (flush) begin
      wr_idx  <= 1'b0;
      rd_idx  <= 1'b0;
      buf_cnt <= 2'd0;
    end else begin
      if (land) begin
        mem[wr_idx] <= ram_rdata;
        wr_idx      <= ~wr_idx;
      end
      if (pop) begin
        rd_idx <= ~rd_idx;
      end
      buf_cnt <= buf_cnt + {1'b0, land} - {1'b0, pop};
    end
  end

  assign m_valid = (buf_cnt != 2'd0);
  assign m_data  = mem[rd_idx];

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// rtl/dpram_fifo_ctrl.sv - stream-to-RAM FIFO controller driving both ports of dual_mem
module dpram_fifo_ctrl #(
  parameter int DATA_W = dpram_pkg::DATA_W,
  parameter int ADDR_W = dpram_pkg::ADDR_W,
  parameter int DEPTH  = dpram_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              mem_en,
  output logic              op_en,
  output logic              write,
  output logic              read,
  output logic [ADDR_W-1:0] wr_address,
  output logic [ADDR_W-1:0] rd_address,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W+1:0] level,
  output logic              empty,
  output logic              full
);

  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  logic              live;
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   occ;
  logic              inflight;
  logic [1:0]        buf_cnt;
  logic [2:0]        slots;
  logic              push;
  logic              pop;
  logic              issue;

  assign occ   = wr_ptr - rd_ptr;
  assign full  = (occ == DEPTH_P);
  assign pop   = m_valid & m_ready;
  assign push  = s_valid & s_ready;

  // Buffer entries committed after this edge; a new read may only be issued if one stays free.
  assign slots = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue = live & ~flush & (occ != '0) & (slots < 3'd2);

  assign s_ready    = live & ~full & ~flush;
  assign mem_en     = live;
  assign op_en      = live;
  assign write      = push;
  assign wr_address = wr_ptr[ADDR_W-1:0];
  assign data_in    = push ? s_data : '0;
  assign read       = issue;
  assign rd_address = rd_ptr[ADDR_W-1:0];

  assign level = {1'b0, occ} + {{(ADDR_W+1){1'b0}}, inflight} + {{ADDR_W{1'b0}}, buf_cnt};
  assign empty = (level == '0);

  // Ready flop: the controller comes alive on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live <= 1'b0;
    end else begin
      live <= 1'b1;
    end
  end

  // Pointer and in-flight tracking; issue only sees registered wr_ptr so a read never hits a same-edge write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      inflight <= issue;
    end
  end

  fifo_out_buf #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .land      (inflight),
    .ram_rdata (ram_rdata),
    .pop       (pop),
    .buf_cnt   (buf_cnt),
    .m_valid   (m_valid),
    .m_data    (m_data)
  );

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb/tb_dpram_fifo_ctrl.sv - scoreboard bench for dpram_fifo_ctrl with a behavioural RAM
module tb_dpram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = '0;
  logic        m_valid;
  wire         m_ready;
  logic [63:0] m_data;
  logic        mem_en, op_en, write, read;
  logic [9:0]  wr_address, rd_address;
  logic [63:0] data_in;
  logic [63:0] ram_rdata = '0;
  logic [11:0] level;
  logic        empty, full;

  logic        rdy_dir = 1'b0;
  logic        rand_mode = 1'b0;
  logic        rnd = 1'b0;
  assign m_ready = rand_mode ? rnd : rdy_dir;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  int          stall_n = 0;
  logic        nb_mode = 1'b0;
  logic        nb_started = 1'b0;
  int          bubbles = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;
  logic [63:0] ram [0:1023];

  always #5 clk = ~clk;

  dpram_fifo_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .mem_en     (mem_en),
    .op_en      (op_en),
    .write      (write),
    .read       (read),
    .wr_address (wr_address),
    .rd_address (rd_address),
    .data_in    (data_in),
    .ram_rdata  (ram_rdata),
    .level      (level),
    .empty      (empty),
    .full       (full)
  );

  // Behavioural dual_mem: registered read, one-cycle latency.
  always @(posedge clk) begin
    if (mem_en && write) ram[wr_address] <= data_in;
    if (mem_en && read)  ram_rdata <= ram[rd_address];
  end

  // Random backpressure source, about 30% ready.
  always @(posedge clk) begin
    #1;
    rnd = ($urandom_range(0, 9) < 3);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (m_valid && prev_stall) check("stall_stable", m_data, prev_data);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%h expected=none", m_data);
        end else begin
          check("out_data", m_data, exp_q.pop_front());
        end
        if (nb_mode) nb_started = 1'b1;
      end else if (nb_mode && nb_started && exp_q.size() != 0) begin
        bubbles++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic push_word(input logic [63:0] d);
    logic acc;
    int   tries;
    s_valid = 1'b1;
    s_data  = d;
    acc     = 1'b0;
    tries   = 0;
    while (!acc && tries < 2000) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      if (acc) exp_q.push_back(d);
      else stall_n++;
      tries++;
    end
    if (!acc) check("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(input string name);
    int n;
    rdy_dir = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_mem_en", 64'({mem_en, op_en, write, read}), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_s_ready_low", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    check("rel_s_ready_high", 64'(s_ready), 64'd1);

    // Single word latency
    rdy_dir = 1'b1;
    push_word(64'hA5);
    s_valid = 1'b0;
    @(negedge clk); check("lat_n0", 64'(m_valid), 64'd0);
    @(negedge clk); check("lat_n1", 64'(m_valid), 64'd0);
    @(negedge clk); check("lat_n2", 64'(m_valid), 64'd1);
    @(negedge clk);
    check("single_level", 64'(level), 64'd0);
    check("single_empty", 64'(empty), 64'd1);

    // Fill to capacity with the consumer stalled
    @(posedge clk); #1;
    rdy_dir = 1'b0;
    for (int i = 0; i < 1026; i++) push_word(64'(i));
    @(negedge clk);
    check("fill_s_ready", 64'(s_ready), 64'd0);
    check("fill_level", 64'(level), 64'd1026);
    check("fill_full", 64'(full), 64'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    drain("fill_drain");

    // Continuous streaming with no backpressure
    stall_n = 0;
    bubbles = 0;
    nb_started = 1'b0;
    nb_mode = 1'b1;
    for (int i = 0; i < 3000; i++) push_word(64'h1000 + 64'(i));
    s_valid = 1'b0;
    drain("stream_drain");
    nb_mode = 1'b0;
    check("stream_in_stalls", 64'(stall_n), 64'd0);
    check("stream_bubbles", 64'(bubbles), 64'd0);

    // Random backpressure
    rand_mode = 1'b1;
    for (int i = 0; i < 200; i++) push_word(64'hB000_0000 + 64'(i));
    s_valid = 1'b0;
    drain("rand_drain");
    rand_mode = 1'b0;

    // Flush with a read in flight and level 5
    rdy_dir = 1'b0;
    for (int i = 0; i < 6; i++) push_word(64'hC0 + 64'(i));
    s_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("pre_flush_level", 64'(level), 64'd6);
    rdy_dir = 1'b1;
    @(negedge clk);
    check("pre_flush_issue", 64'(read), 64'd1);
    @(posedge clk); #1;
    rdy_dir = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("flush_level5", 64'(level), 64'd5);
    check("flush_s_ready", 64'(s_ready), 64'd0);
    check("flush_no_issue", 64'(read), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("post_flush_level", 64'(level), 64'd0);
    check("post_flush_m_valid", 64'(m_valid), 64'd0);
    check("post_flush_empty", 64'(empty), 64'd1);
    @(posedge clk); #1;
    rdy_dir = 1'b1;
    push_word(64'h77);
    s_valid = 1'b0;
    drain("flush_drain");

    // Asynchronous reset mid-stream
    for (int i = 0; i < 20; i++) push_word(64'hD00 + 64'(i));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_s_ready", 64'(s_ready), 64'd0);
    check("mid_rst_m_valid", 64'(m_valid), 64'd0);
    check("mid_rst_m_data", m_data, 64'd0);
    check("mid_rst_ctl", 64'({mem_en, op_en, write, read, full}), 64'd0);
    check("mid_rst_addr", 64'({wr_address, rd_address}), 64'd0);
    check("mid_rst_data_in", data_in, 64'd0);
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_empty", 64'(empty), 64'd1);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_s_ready_low", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    check("mid_rel_s_ready_high", 64'(s_ready), 64'd1);
    push_word(64'h99);
    s_valid = 1'b0;
    drain("reset_drain");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpram_fifo_ctrl.md
# dpram_fifo_ctrl

Stream-to-RAM FIFO controller that owns both ports of the 64x1024 dual-port RAM (`dual_mem`). It turns a valid/ready input stream into RAM writes and turns RAM reads into a valid/ready output stream. It tracks pointers, occupancy and full/empty, and hides the RAM's one-cycle registered read latency behind a 2-entry output buffer. It sits between the upstream producer and the RAM, and its read side feeds the downstream consumer.

## Interface
Parameters:
- DATA_W, 64, word width; must match RAM width.
- ADDR_W, 10, RAM address width.
- DEPTH, 1024, RAM entries; must equal 2**ADDR_W.

Ports:
- clk  in  1  RAM/system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous clear of all contents.
- s_valid  in  1  input word valid.
- s_ready  out  1  controller can accept.
- s_data  in  DATA_W  input word.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts.
- m_data  out  DATA_W  output word.
- mem_en  out  1  to RAM mem_en.
- op_en  out  1  to RAM op_en.
- write  out  1  to RAM write.
- read  out  1  to RAM read.
- wr_address  out  ADDR_W  to RAM wr_address.
- rd_address  out  ADDR_W  to RAM rd_address.
- data_in  out  DATA_W  to RAM data_in.
- ram_rdata  in  DATA_W  from RAM data_out.
- level  out  ADDR_W+2  total words held, 0..DEPTH+2.
- empty  out  1  level == 0.
- full  out  1  RAM occupancy == DEPTH.

## Operation
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits, with an MSB wrap bit. RAM occupancy is wr_ptr - rd_ptr, modulo 2**(ADDR_W+1). full means occupancy == DEPTH. Address is the pointer's low ADDR_W bits, so the address wraps 1023 -> 0.
- Ready flop: `live` is cleared by reset and set on the first clk after rst_n deasserts.
- RAM enables: mem_en = op_en = live.
- s_ready = live & !full & !flush.
- Write side: push = s_valid & s_ready. On a push: write = 1, wr_address = wr_ptr[ADDR_W-1:0], data_in = s_data, and wr_ptr increments.
- Read issue: issue = live & !flush & (occupancy != 0) & (buf_cnt + inflight - pop < 2), where pop = m_valid & m_ready.
- On an issue: read = 1, rd_address = rd_ptr[ADDR_W-1:0], rd_ptr increments, and the inflight flop is set for the next cycle.
- Landing: when inflight = 1, ram_rdata is captured into the output buffer that cycle.
- Output buffer: 2-entry FIFO, where m_valid = buf_cnt != 0 and m_data = head entry. Pop and land in the same cycle are legal.
- Level: level = occupancy + inflight + buf_cnt.
- Flush (synchronous, one cycle): wr_ptr = rd_ptr = 0, buf_cnt = 0, inflight = 0. A read in flight that cycle is discarded. Any s_valid in the flush cycle is not accepted.
- Simultaneous push and issue on an empty RAM is not possible: issue needs occupancy != 0 from registered pointers.

## Timing
- Reset values: s_ready 0, m_valid 0, m_data 0, write 0, read 0, mem_en 0, op_en 0, wr_address 0, rd_address 0, data_in 0, level 0, empty 1, full 0.
- Latency: a word pushed at edge N is first issued at N+1, lands at N+2, and drives m_valid from cycle N+2. Minimum push-to-m_valid latency is 2 cycles.
- Throughput: with m_ready held at 1, the controller sustains 1 word/cycle in and out.
- Write/read hazard: a read never targets an address written on the same edge, because issue uses the registered wr_ptr. The RAM's old-data behaviour on a same-edge read/write collision is therefore never exposed.
- Handshake: m_valid and m_data hold stable while m_valid & !m_ready. s_ready may drop combinationally only on full, flush or !live.
- Reset mid-operation: all state clears asynchronously and contents are lost. ram_rdata is ignored until inflight is set.

## Structure
- Package `dpram_pkg`: DATA_W, ADDR_W and DEPTH constants, plus the pointer typedef (logic [ADDR_W:0]). It is shared with `dual_mem` instantiation sites.
- Sub-module `fifo_out_buf`: the 2-entry output buffer, with inputs land, ram_rdata, pop and flush, and outputs buf_cnt, m_valid and m_data.
- Top-level holds the pointers, issue logic, inflight flop, live flop and level.

## Test plan
- Reset, then push 0xA5 with m_ready = 1 -> m_valid high 2 cycles later with m_data = 0xA5; level returns to 0 and empty = 1.
- Push 1026 words 0..1025 with m_ready = 0 -> s_ready low after the 1026th accept; level = 1026; full = 1. Drain -> words come out in order 0..1025.
- Continuous push and pop with m_ready = 1 for 3000 words -> no bubbles after the first word; addresses wrap past 1023 and the data order is intact.
- Random m_ready backpressure at 30% duty -> no loss or duplication; m_data is stable while stalled.
- Flush asserted with a read in flight and level = 5 -> next cycle level = 0, m_valid = 0; a subsequent push of 0x77 emerges first.
- rst_n pulsed low mid-stream -> all outputs take their reset values immediately; s_ready returns 1 one cycle after deassert.
